pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter XLEN, default 32; PC and address width in bits.
REQ-002 SHALL have parameter RESET_VECTOR, default 0; PC value loaded on reset.
REQ-003 SHALL have parameter ILEN_BYTES, default 4; sequential increment in bytes.
REQ-004 SHALL have parameter RAS_DEPTH, default 4; return-address-stack entries, power of two, at least 2.
REQ-005 SHALL have port clock  input  1  clock; all state updates on the falling edge.
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port stall  input  1  hold the current PC.
REQ-008 SHALL have port fetch_ready  input  1  fetch stage accepts pc_out this cycle.
REQ-009 SHALL have port halt  input  1  request to enter the HALT state.
REQ-010 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-011 SHALL have port redirect_pc  input  XLEN  redirect target.
REQ-012 SHALL have port trap_valid  input  1  exception/trap request.
REQ-013 SHALL have port trap_vector  input  XLEN  trap handler address.
REQ-014 SHALL have port call_valid  input  1  current fetch is a call.
REQ-015 SHALL have port ret_valid  input  1  current fetch is a return.
REQ-016 SHALL have port pc_out  output  XLEN  current fetch PC.
REQ-017 SHALL have port pc_valid  output  1  pc_out is a valid fetch address.
REQ-018 SHALL have port ras_empty  output  1  RAS holds no entries.
REQ-019 SHALL have port ras_full  output  1  RAS holds RAS_DEPTH entries.

Function
REQ-020 SHALL implement states BOOT, RUN and HALT.
REQ-021 SHALL go BOOT->RUN on the first edge after reset deasserts; pc_valid=0 in BOOT, pc_out=RESET_VECTOR.
REQ-022 SHALL go RUN->HALT on halt with no trap_valid or redirect_valid; pc_valid=0 and pc_out held in HALT.
REQ-023 SHALL leave HALT for RUN only on trap_valid or redirect_valid, loading the target; halt is ignored while in HALT.
REQ-024 SHALL define advance = RUN & pc_valid & fetch_ready & ~stall.
REQ-025 SHALL resolve each edge with priority trap > redirect > RAS pop > stall/hold > sequential.
REQ-026 SHALL load trap_vector on trap_valid, in any non-BOOT state, regardless of stall or fetch_ready.
REQ-027 SHALL load redirect_pc on redirect_valid, regardless of stall or fetch_ready.
REQ-028 SHALL force the low log2(ILEN_BYTES) bits of every loaded target to zero.
REQ-029 SHALL load pc_out+ILEN_BYTES on advance with no higher-priority event, wrapping modulo 2^XLEN (0xFFFFFFFC -> 0x00000000 at the defaults).
REQ-030 SHALL hold pc_out when not advancing and no trap/redirect occurs.
REQ-031 SHALL register pc_out with a next-PC latency of exactly one edge from the deciding inputs.

Reset
REQ-032 SHALL, on reset high at a falling edge, set state=BOOT, pc_out=RESET_VECTOR, pc_valid=0, RAS count=0, ras_empty=1, ras_full=0.
REQ-033 SHALL give reset priority over every other input, including a trap or redirect in the same cycle and reset asserted mid-HALT.

Configuration
REQ-034 SHALL compile the RAS in only when macro PC_GEN_RAS_EN is defined.
REQ-035 SHALL, with PC_GEN_RAS_EN, push pc_out+ILEN_BYTES on advance & call_valid.
REQ-036 SHALL, with PC_GEN_RAS_EN, pop the top entry into pc_out on advance & ret_valid & ~ras_empty.
REQ-037 SHALL, on ret_valid with ras_empty, treat the cycle as a sequential advance with no pop.
REQ-038 SHALL, on a push while full, overwrite the oldest entry circularly; count stays RAS_DEPTH.
REQ-039 SHALL, on simultaneous call_valid and ret_valid, jump to the old top and replace the top with pc_out+ILEN_BYTES; count is unchanged.
REQ-040 SHALL leave RAS contents unchanged on trap or redirect; only reset clears the RAS.
REQ-041 SHALL, without PC_GEN_RAS_EN, ignore call_valid and ret_valid, tie ras_empty=1 and ras_full=0, and instantiate no RAS storage.

Structure
REQ-042 SHALL take the state enum typedef, the default XLEN and ILEN_BYTES constants from shared package pc_gen_pkg.
REQ-043 SHALL implement the RAS as sub-module pc_ras (push, pop, top, empty, full), instantiated only under PC_GEN_RAS_EN.

Verification
REQ-044 SHALL cover reset, then 3 edges with fetch_ready=1 -> pc_out 0x0 (BOOT, pc_valid=0), 0x0 valid, 0x4, 0x8.
REQ-045 SHALL cover stall=1 with redirect_valid=1 and redirect_pc=0x103 in the same cycle -> pc_out=0x100 next edge.
REQ-046 SHALL cover trap_valid (trap_vector=0x80) with redirect_valid (redirect_pc=0x200) together -> pc_out=0x80.
REQ-047 SHALL cover halt at pc_out=0x10 -> pc_valid=0 with pc held at 0x10, then redirect to 0x40 -> RUN with pc_out=0x40.
REQ-048 SHALL cover, with RAS_EN, a call at 0x20 then a return at 0x300 -> pc_out=0x24; then 5 calls with RAS_DEPTH=4 -> ras_full=1 and the oldest entry lost.
REQ-049 SHALL cover sequential advance at pc_out=0xFFFFFFFC -> pc_out=0x00000000.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared types and default widths for the program-counter generator slice.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

  localparam int PC_XLEN       = 32;
  localparam int PC_ILEN_BYTES = 4;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras
  import pc_gen_pkg::*;
#(
  parameter int XLEN  = PC_XLEN,
  parameter int DEPTH = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int PW = $clog2(DEPTH);

  logic [XLEN-1:0] mem_p0 [DEPTH];
  logic [PW-1:0]   sp_p0;
  logic [PW:0]     cnt_p0;
  logic [PW-1:0]   top_idx;
  logic            do_pop;

  assign top_idx = sp_p0 - PW'(1);
  assign top     = mem_p0[top_idx];
  assign empty   = (cnt_p0 == '0);
  assign full    = (cnt_p0 == (PW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;

  // Stage 0: pointer/count update; push+pop together replaces the top in place
  always_ff @(negedge clock) begin
    if (reset) begin
      sp_p0  <= '0;
      cnt_p0 <= '0;
    end else if (push && !do_pop) begin
      sp_p0 <= sp_p0 + PW'(1);
      if (!full) cnt_p0 <= cnt_p0 + (PW+1)'(1);
    end else if (do_pop && !push) begin
      sp_p0  <= sp_p0 - PW'(1);
      cnt_p0 <= cnt_p0 - (PW+1)'(1);
    end
  end

  always_ff @(negedge clock) begin
    if (push && do_pop) mem_p0[top_idx] <= push_data;
    else if (push)      mem_p0[sp_p0]   <= push_data;
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator with BOOT/RUN/HALT control; the return-address stack is
// built in only when PC_GEN_RAS_EN is defined. All state moves on the falling edge.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN         = PC_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              ILEN_BYTES   = PC_ILEN_BYTES,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            fetch_ready,
  input  logic            halt,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            call_valid,
  input  logic            ret_valid,
  output logic [XLEN-1:0] pc_out,
  output logic            pc_valid,
  output logic            ras_empty,
  output logic            ras_full
);

  localparam logic [XLEN-1:0] ILEN_INC   = XLEN'(ILEN_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(ILEN_INC - XLEN'(1));

  function automatic logic [XLEN-1:0] align(input logic [XLEN-1:0] addr);
    return addr & ALIGN_MASK;
  endfunction

  pc_state_e       state_p0, state_nxt;
  logic [XLEN-1:0] pc_p0, pc_nxt, seq_pc, ras_top;
  logic            advance, step, pop;

  assign seq_pc  = pc_p0 + ILEN_INC;
  assign advance = (state_p0 == RUN) & pc_valid & fetch_ready & ~stall;
  // A halt request in RUN freezes the PC rather than letting it advance.
  assign step    = advance & ~trap_valid & ~redirect_valid & ~halt;

`ifdef PC_GEN_RAS_EN
  logic push;

  assign push = step & call_valid;
  assign pop  = step & ret_valid & ~ras_empty;

  pc_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (seq_pc),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );
`else
  logic unused_ras;

  assign unused_ras = &{1'b0, call_valid, ret_valid};
  assign pop        = 1'b0;
  assign ras_top    = '0;
  assign ras_empty  = 1'b1;
  assign ras_full   = 1'b0;
`endif

  // Stage 0: control and PC registers
  always_ff @(negedge clock) begin
    if (reset) state_p0 <= BOOT;
    else       state_p0 <= state_nxt;
  end

  always_ff @(negedge clock) begin
    if (reset) pc_p0 <= RESET_VECTOR;
    else       pc_p0 <= pc_nxt;
  end

  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      BOOT:    state_nxt = RUN;
      RUN:     if (halt && !trap_valid && !redirect_valid) state_nxt = HALT;
      HALT:    if (trap_valid || redirect_valid) state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
  end

  always_comb begin
    pc_nxt = pc_p0;
    if (trap_valid && state_p0 != BOOT) pc_nxt = align(trap_vector);
    else if (redirect_valid)            pc_nxt = align(redirect_pc);
    else if (pop)                       pc_nxt = align(ras_top);
    else if (step)                      pc_nxt = seq_pc;
  end

  always_comb begin
    pc_valid = (state_p0 == RUN);
    pc_out   = pc_p0;
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen; RAS vectors are added when PC_GEN_RAS_EN is defined.
module tb_pc_gen;

  logic        clock, reset, stall, fetch_ready, halt;
  logic        redirect_valid, trap_valid, call_valid, ret_valid;
  logic [31:0] redirect_pc, trap_vector, pc_out;
  logic        pc_valid, ras_empty, ras_full;

  int vectors = 0;
  int fails   = 0;

  pc_gen #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0),
    .ILEN_BYTES   (4),
    .RAS_DEPTH    (4)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall),
    .fetch_ready    (fetch_ready),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .trap_valid     (trap_valid),
    .trap_vector    (trap_vector),
    .call_valid     (call_valid),
    .ret_valid      (ret_valid),
    .pc_out         (pc_out),
    .pc_valid       (pc_valid),
    .ras_empty      (ras_empty),
    .ras_full       (ras_full)
  );

  initial clock = 1'b1;
  always #5 clock = ~clock;

  // One active (falling) edge, then settle on the rising edge for sampling.
  task automatic tick();
    @(negedge clock);
    @(posedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic redirect_to(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; fetch_ready = 1'b0; halt = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; trap_valid = 1'b0; trap_vector = '0;
    call_valid = 1'b0; ret_valid = 1'b0;

    tick();
    check("reset_pc",    pc_out,    32'h0);
    check("reset_valid", pc_valid,  32'h0);
    check("reset_empty", ras_empty, 32'h1);
    check("reset_full",  ras_full,  32'h0);

    reset = 1'b0; fetch_ready = 1'b1;
    tick();
    check("boot_run_pc",    pc_out,   32'h0);
    check("boot_run_valid", pc_valid, 32'h1);
    tick();
    check("seq_4", pc_out, 32'h4);
    tick();
    check("seq_8", pc_out, 32'h8);

    stall = 1'b1;
    redirect_to(32'h103);
    check("stall_redirect_aligned", pc_out, 32'h100);
    tick();
    check("stall_hold", pc_out, 32'h100);
    stall = 1'b0;
    tick();
    check("unstall_seq", pc_out, 32'h104);

    trap_valid = 1'b1; trap_vector = 32'h80;
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    trap_valid = 1'b0; redirect_valid = 1'b0;
    check("trap_over_redirect", pc_out, 32'h80);

    fetch_ready = 1'b0;
    tick();
    check("not_ready_hold", pc_out, 32'h80);
    fetch_ready = 1'b1;

    redirect_to(32'h10);
    check("pre_halt_pc", pc_out, 32'h10);
    halt = 1'b1;
    tick();
    check("halt_pc",    pc_out,   32'h10);
    check("halt_valid", pc_valid, 32'h0);
    tick();
    check("halt_stays_pc",    pc_out,   32'h10);
    check("halt_stays_valid", pc_valid, 32'h0);
    redirect_to(32'h40);
    halt = 1'b0;
    check("halt_exit_pc",    pc_out,   32'h40);
    check("halt_exit_valid", pc_valid, 32'h1);
    tick();
    check("post_halt_seq", pc_out, 32'h44);

    redirect_to(32'hFFFF_FFFC);
    check("pre_wrap", pc_out, 32'hFFFF_FFFC);
    tick();
    check("wrap", pc_out, 32'h0);

    redirect_to(32'h50);
    halt = 1'b1;
    tick();
    check("halt2_valid", pc_valid, 32'h0);
    reset = 1'b1; trap_valid = 1'b1; trap_vector = 32'h80;
    tick();
    reset = 1'b0; trap_valid = 1'b0; halt = 1'b0;
    check("reset_over_trap_pc",    pc_out,   32'h0);
    check("reset_over_trap_valid", pc_valid, 32'h0);
    tick();
    check("reboot_valid", pc_valid, 32'h1);
    check("reboot_pc",    pc_out,   32'h0);

`ifdef PC_GEN_RAS_EN
    redirect_to(32'h20);
    call_valid = 1'b1;
    tick();
    call_valid = 1'b0;
    check("call_seq",   pc_out,    32'h24);
    check("call_empty", ras_empty, 32'h0);
    redirect_to(32'h300);
    ret_valid = 1'b1;
    tick();
    ret_valid = 1'b0;
    check("ret_pc",    pc_out,    32'h24);
    check("ret_empty", ras_empty, 32'h1);

    redirect_to(32'h1000);
    call_valid = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    call_valid = 1'b0;
    check("five_calls_pc", pc_out,   32'h1014);
    check("ras_full",      ras_full, 32'h1);
    redirect_to(32'h2000);
    ret_valid = 1'b1;
    tick();
    check("pop_1", pc_out, 32'h1014);
    tick();
    check("pop_2", pc_out, 32'h1010);
    tick();
    check("pop_3", pc_out, 32'h100C);
    tick();
    check("pop_4",       pc_out,    32'h1008);
    check("pop_4_empty", ras_empty, 32'h1);
    tick();
    ret_valid = 1'b0;
    check("oldest_lost_seq", pc_out, 32'h100C);

    redirect_to(32'h20);
    call_valid = 1'b1;
    tick();
    redirect_to(32'h500);
    ret_valid = 1'b1;
    tick();
    call_valid = 1'b0;
    check("call_ret_pc",    pc_out,    32'h24);
    check("call_ret_count", ras_empty, 32'h0);
    tick();
    ret_valid = 1'b0;
    check("replaced_top", pc_out,    32'h504);
    check("replaced_pop", ras_empty, 32'h1);
`else
    redirect_to(32'h20);
    call_valid = 1'b1;
    tick();
    call_valid = 1'b0;
    check("no_ras_call_seq",   pc_out,    32'h24);
    check("no_ras_call_empty", ras_empty, 32'h1);
    redirect_to(32'h300);
    ret_valid = 1'b1;
    tick();
    ret_valid = 1'b0;
    check("no_ras_ret_seq", pc_out,   32'h304);
    check("no_ras_full",    ras_full, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
